// File: rtl/mod3_sched_if.sv
// Request/result bundle between word producers, the mod-3 scheduler and the result consumer.
interface mod3_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [IDW-1:0]        res_id;
  logic [1:0]            res_residue;
  logic                  res_div;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_residue, res_div
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_residue, res_div
  );
endinterface

// File: rtl/mod3_sched.sv
// Round-robin arbiter sharing one serial MSB-first mod-3 residue engine among NREQ requesters.
module mod3_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  mod3_sched_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [WIDTH-1:0] shreg;
  logic [1:0]       residue;
  logic [1:0]       residue_next;
  logic [CW-1:0]    cnt;
  logic             settle;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     cand;
  logic [WIDTH-1:0] sel_word;

  // Walk the requesters starting at ptr, wrapping once, and take the first valid one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) sel_word = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  // settle blanks the single IDLE cycle that follows a handoff, so no grant overlaps a result.
  always_comb begin
    bus.req_ready = '0;
    if (resetn && state == IDLE && !settle && grant_found) bus.req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    case ({residue, shreg[WIDTH-1]})
      3'b000:  residue_next = 2'd0;
      3'b001:  residue_next = 2'd1;
      3'b010:  residue_next = 2'd2;
      3'b011:  residue_next = 2'd0;
      3'b100:  residue_next = 2'd1;
      3'b101:  residue_next = 2'd2;
      default: residue_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ptr     <= '0;
      id      <= '0;
      shreg   <= '0;
      residue <= 2'd0;
      cnt     <= '0;
      settle  <= 1'b0;
    end else begin
      settle <= 1'b0;
      case (state)
        IDLE: begin
          if (!settle && grant_found) begin
            shreg   <= sel_word;
            residue <= 2'd0;
            id      <= grant_idx;
            cnt     <= CW'(WIDTH-1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          residue <= residue_next;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          if (bus.res_ready) begin
            ptr    <= (id == IDW'(NREQ-1)) ? '0 : id + 1'b1;
            settle <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid   = (state == DONE);
  assign bus.res_id      = id;
  assign bus.res_residue = residue;
  assign bus.res_div     = (state == DONE) && (residue == 2'd0);
endmodule
